// File: rtl/matrix_scan_pkg.sv
// Shared definitions for the matrix scan receiver: FSM states, row geometry
// and the row-strobe rotation helper.
package matrix_scan_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam int unsigned ROWS      = 8;
    localparam logic [7:0]  START_ROW = 8'b0000_0001;

    // Next row strobe in scan order: 0000_0001 -> 1000_0000 -> 0100_0000 ...
    function automatic logic [7:0] rotr(input logic [7:0] r);
        return {r[0], r[7:1]};
    endfunction

endpackage

// File: rtl/onehot_chk.sv
// Combinational one-hot check and bit-index encoder for the row strobe.
module onehot_chk
    import matrix_scan_pkg::*;
(
    input  logic [7:0] row,
    output logic       is_onehot,
    output logic [2:0] idx
);

    // Zero and multi-hot strobes are both rejected; idx is only meaningful when one-hot.
    always_comb begin
        idx       = '0;
        is_onehot = (row != '0) && ((row & (row - 8'd1)) == '0);
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (row[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/matrix_scan_rx.sv
// Matrix scan receiver: assembles 8 row strobes (rotating right from
// 0000_0001) into a frame, publishing it one cycle after the last row.
// Optional feature: define SCAN_ERR_CNT_EN to add a saturating err_cnt output.
module matrix_scan_rx
    import matrix_scan_pkg::*;
#(
    parameter int COL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scan_en,
    input  logic [7:0]           row,
    input  logic [COL_W-1:0]     col,
    output logic [8*COL_W-1:0]   frame,
    output logic                 frame_valid,
    output logic [2:0]           row_pos,
    output logic                 err,
    output logic                 locked
`ifdef SCAN_ERR_CNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);

    state_t                        state;
    logic [7:0]                    last_row;
    logic [ROWS-1:0][COL_W-1:0]    work;
    logic [ROWS-1:0][COL_W-1:0]    frame_q;
    logic                          pend;
    logic                          is_onehot;
    logic [2:0]                    idx;
    logic                          accept;
    logic                          viol;

    onehot_chk u_onehot_chk (
        .row       (row),
        .is_onehot (is_onehot),
        .idx       (idx)
    );

    assign frame = frame_q;

    // Classify the current sample while capturing: in-sequence row or protocol violation.
    always_comb begin
        accept = 1'b0;
        viol   = 1'b0;
        if (scan_en && state == CAPTURE) begin
            accept = is_onehot && (row == rotr(last_row));
            viol   = !accept;
        end
    end

    // Receiver FSM with registered outputs; frame publication lags the last row by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            last_row    <= '0;
            work        <= '0;
            frame_q     <= '0;
            pend        <= 1'b0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            row_pos     <= '0;
            locked      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            err         <= 1'b0;
            // The copy reads the buffer before any write from this cycle's sample.
            if (pend) begin
                frame_q     <= work;
                frame_valid <= 1'b1;
                pend        <= 1'b0;
            end
            if (scan_en) begin
                case (state)
                    HUNT: begin
                        if (row == START_ROW) begin
                            work[0]  <= col;
                            row_pos  <= '0;
                            last_row <= row;
                            state    <= CAPTURE;
                            locked   <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (accept) begin
                            work[idx] <= col;
                            row_pos   <= idx;
                            last_row  <= row;
                            if (rotr(row) == START_ROW) begin
                                pend <= 1'b1;
                            end
                        end else begin
                            err  <= 1'b1;
                            // Later write to slot 0 overrides the clear when restarting.
                            work <= '0;
                            if (row == START_ROW) begin
                                work[0]  <= col;
                                row_pos  <= '0;
                                last_row <= row;
                            end else begin
                                state  <= HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SCAN_ERR_CNT_EN
    // Saturating count of protocol violations, bumped on the edge that raises err.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (viol && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_scan_rx.sv
// Self-checking bench for matrix_scan_rx: directed scenarios plus random
// traffic, all checked every cycle against a frame-level behavioural model.
module tb_matrix_scan_rx;

    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            scan_en;
    logic [7:0]      row;
    logic [CW-1:0]   col;
    logic [8*CW-1:0] frame;
    logic            frame_valid;
    logic [2:0]      row_pos;
    logic            err;
    logic            locked;
`ifdef SCAN_ERR_CNT_EN
    logic [7:0]      err_cnt;
`endif

    matrix_scan_rx #(.COL_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .row         (row),
        .col         (col),
        .frame       (frame),
        .frame_valid (frame_valid),
        .row_pos     (row_pos),
        .err         (err),
        .locked      (locked)
`ifdef SCAN_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fv_seen  = 0;

    // Model: scan order expressed as a list of bit indices, row k = 1 << seq[n].
    int                    seq [8] = '{0, 7, 6, 5, 4, 3, 2, 1};
    bit                    m_lock, m_pend, m_fv, m_err;
    int                    m_n;
    logic [2:0]            m_pos;
    logic [7:0][CW-1:0]    m_buf, m_frame;
    int                    m_errcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_expected_row();
        if (!m_lock) return 8'h01;
        return 8'(1 << seq[m_n]);
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [7:0] rw,
                              input logic [CW-1:0] c);
        m_fv  = 0;
        m_err = 0;
        if (r) begin
            m_lock = 0; m_pend = 0; m_n = 0; m_pos = '0;
            m_buf = '0; m_frame = '0; m_errcnt = 0;
            return;
        end
        if (m_pend) begin
            m_frame = m_buf;
            m_fv    = 1;
            m_pend  = 0;
        end
        if (!e) return;
        if (!m_lock) begin
            if (rw == 8'h01) begin
                m_buf[0] = c; m_n = 1; m_pos = '0; m_lock = 1;
            end
        end else if (rw == 8'(1 << seq[m_n])) begin
            m_buf[seq[m_n]] = c;
            m_pos = 3'(seq[m_n]);
            m_n++;
            if (m_n == 8) begin
                m_pend = 1;
                m_n    = 0;
            end
        end else begin
            m_err = 1;
            if (m_errcnt < 255) m_errcnt++;
            m_buf = '0;
            if (rw == 8'h01) begin
                m_buf[0] = c; m_n = 1; m_pos = '0;
            end else begin
                m_lock = 0; m_n = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("frame", frame, m_frame);
        chk("frame_valid", frame_valid, m_fv);
        chk("err", err, m_err);
        chk("row_pos", row_pos, m_pos);
        chk("locked", locked, m_lock);
`ifdef SCAN_ERR_CNT_EN
        chk("err_cnt", err_cnt, 64'(m_errcnt));
`endif
        if (frame_valid) fv_seen++;
    endtask

    task automatic tick(input logic r, input logic e, input logic [7:0] rw,
                        input logic [CW-1:0] c);
        rst = r; scan_en = e; row = rw; col = c;
        @(posedge clk);
        model_step(r, e, rw, c);
        #1;
        compare_all();
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    // Send rows seq[from..7] with col = base + bit index; optional 1-3 cycle gaps.
    task automatic send_rows(input int from, input logic [7:0] base, input bit gaps);
        for (int k = from; k < 8; k++) begin
            tick(1'b0, 1'b1, 8'(1 << seq[k]), base + 8'(seq[k]));
            if (gaps) repeat ($urandom_range(1, 3)) idle();
        end
    endtask

    initial begin
        rst = 1'b1; scan_en = 1'b0; row = '0; col = '0;

        // Reset state
        tick(1'b1, 1'b0, 8'h00, 8'h00);
        tick(1'b1, 1'b1, 8'h01, 8'h55);
        chk("rst_frame", frame, 64'h0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_pos", row_pos, 3'd0);

        // Clean frame: frame_valid one cycle after the 8th sample
        fv_seen = 0;
        send_rows(0, 8'hA0, 1'b0);
        chk("fv_not_on_sample_edge", frame_valid, 1'b0);
        chk("last_row_pos", row_pos, 3'd1);
        chk("still_locked", locked, 1'b1);
        idle();
        chk("fv_pulse", frame_valid, 1'b1);
        chk("frame_lit", frame, 64'hA7A6_A5A4_A3A2_A1A0);
        idle();
        chk("fv_one_cycle", frame_valid, 1'b0);
        chk("fv_count_clean", fv_seen, 1);

        // Same frame with scan_en gaps
        fv_seen = 0;
        send_rows(0, 8'hA0, 1'b1);
        repeat (3) idle();
        chk("fv_count_gaps", fv_seen, 1);
        chk("frame_gaps_lit", frame, 64'hA7A6_A5A4_A3A2_A1A0);

        // Bad 4th sample (multi-hot) drops to HUNT
        fv_seen = 0;
        tick(1'b0, 1'b1, 8'h01, 8'h11);
        tick(1'b0, 1'b1, 8'h80, 8'h12);
        tick(1'b0, 1'b1, 8'h40, 8'h13);
        tick(1'b0, 1'b1, 8'h0C, 8'h14);
        chk("viol_err", err, 1'b1);
        chk("viol_unlocked", locked, 1'b0);
        idle();
        chk("viol_err_clears", err, 1'b0);
        chk("viol_frame_kept", frame, 64'hA7A6_A5A4_A3A2_A1A0);
        chk("viol_no_fv", fv_seen, 0);

        // Mid-frame restart at 0000_0001 stays locked and completes
        fv_seen = 0;
        tick(1'b0, 1'b1, 8'h01, 8'h30);
        tick(1'b0, 1'b1, 8'h80, 8'h37);
        tick(1'b0, 1'b1, 8'h40, 8'h36);
        tick(1'b0, 1'b1, 8'h01, 8'h50);
        chk("restart_err", err, 1'b1);
        chk("restart_locked", locked, 1'b1);
        chk("restart_pos", row_pos, 3'd0);
        send_rows(1, 8'h50, 1'b0);
        idle();
        chk("restart_fv", frame_valid, 1'b1);
        chk("restart_frame_lit", frame, 64'h5756_5554_5352_5150);

        // HUNT ignores rows until 0000_0001
        tick(1'b1, 1'b0, 8'h00, 8'h00);
        fv_seen = 0;
        for (int k = 6; k >= 1; k--) begin
            tick(1'b0, 1'b1, 8'(1 << k), 8'h99);
            chk("hunt_no_err", err, 1'b0);
            chk("hunt_unlocked", locked, 1'b0);
        end
        send_rows(0, 8'h60, 1'b0);
        idle();
        chk("hunt_then_fv", frame_valid, 1'b1);
        chk("hunt_frame_lit", frame, 64'h6766_6564_6362_6160);

        // Reset mid-frame discards it
        fv_seen = 0;
        tick(1'b0, 1'b1, 8'h01, 8'h70);
        tick(1'b0, 1'b1, 8'h80, 8'h77);
        tick(1'b0, 1'b1, 8'h40, 8'h76);
        tick(1'b1, 1'b1, 8'h20, 8'h75);
        send_rows(4, 8'h70, 1'b0);
        repeat (2) idle();
        chk("rst_mid_no_fv", fv_seen, 0);
        chk("rst_mid_frame", frame, 64'h0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int sel;
            logic [7:0] rw;
            sel = $urandom_range(0, 9);
            if (sel < 6)       rw = model_expected_row();
            else if (sel == 6) rw = 8'h01;
            else if (sel == 7) rw = 8'(1 << $urandom_range(0, 7));
            else if (sel == 8) rw = 8'($urandom);
            else               rw = 8'h00;
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rw, 8'($urandom));
        end

`ifdef SCAN_ERR_CNT_EN
        tick(1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b1, 8'h01, 8'h00);
            tick(1'b0, 1'b1, 8'h00, 8'h00);
        end
        chk("err_cnt_sat", err_cnt, 8'd255);
        tick(1'b1, 1'b0, 8'h00, 8'h00);
        chk("err_cnt_rst", err_cnt, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
